// File: rtl/gat_bram_bridge.sv
// -----------------------------------------------------------------------------
// gat_bram_bridge
//
// Purpose:
//   Bridges a narrow host write bus onto NUM_CH wide internal BRAM write
//   ports. The host streams each channel's contents as consecutive
//   TOP_WIDTH beats at increasing byte addresses. The bridge packs BEATS
//   beats into one DATA_W word and issues a single-cycle internal write.
//   Each channel tracks its own progress against an expected depth. It
//   flags completion (load_done) or a protocol violation (load_err).
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   load_start  in   one-cycle pulse, re-arms every channel
//   cfg_depth   in   NUM_CH*ADDR_W, per-channel expected word count
//                    (channel c at [c*ADDR_W +: ADDR_W]), sampled on load_start
//   wr_en       in   host write strobe
//   wr_ch       in   CH_W, target channel of the host write
//   wr_addr     in   host byte address: [1:0] ignored, then beat, then word
//   wr_din      in   TOP_WIDTH, host write data
//   bram_we     out  NUM_CH, one-hot internal write enable (one-cycle pulse)
//   bram_addr   out  ADDR_W, internal word address
//   bram_din    out  DATA_W, packed internal word (beat k in lane k)
//   load_done   out  NUM_CH, sticky per-channel completion flag
//   load_err    out  NUM_CH, sticky per-channel error flag
//   all_ready   out  registered: every channel done and none in error
// -----------------------------------------------------------------------------
module gat_bram_bridge #(
    parameter  int TOP_WIDTH = 32,
    parameter  int NUM_CH    = 4,
    parameter  int DATA_W    = 64,
    parameter  int ADDR_W    = 18,
    localparam int BEATS     = (DATA_W + TOP_WIDTH - 1) / TOP_WIDTH,
    localparam int BEAT_W    = $clog2(BEATS),
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int WA_W      = ADDR_W + BEAT_W + 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_start,
    input  logic [NUM_CH*ADDR_W-1:0]   cfg_depth,
    input  logic                       wr_en,
    input  logic [CH_W-1:0]            wr_ch,
    input  logic [WA_W-1:0]            wr_addr,
    input  logic [TOP_WIDTH-1:0]       wr_din,
    output logic [NUM_CH-1:0]          bram_we,
    output logic [ADDR_W-1:0]          bram_addr,
    output logic [DATA_W-1:0]          bram_din,
    output logic [NUM_CH-1:0]          load_done,
    output logic [NUM_CH-1:0]          load_err,
    output logic                       all_ready
);

    // Beat counters need at least one bit even when a word is a single beat.
    localparam int BI_W  = (BEAT_W > 0) ? BEAT_W : 1;
    localparam int BUF_W = BEATS * TOP_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Host address decode (shared by all channels)
    // ------------------------------------------------------------------
    logic [BI_W-1:0]   w_beat;
    logic [ADDR_W-1:0] w_word;
    logic              w_last;

    generate
        if (BEATS > 1) begin : g_beat_dec
            assign w_beat = wr_addr[BEAT_W+1:2];
        end else begin : g_beat_one
            assign w_beat = '0;
        end
    endgenerate

    assign w_word = wr_addr[BEAT_W+2 +: ADDR_W];
    assign w_last = (w_beat == BI_W'(BEATS - 1));

    // ------------------------------------------------------------------
    // Per-channel load FSMs
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] w_emit;
    logic [BUF_W-1:0]  w_buf_all [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t            r_state;
            logic [BI_W-1:0]   r_beat;
            logic [ADDR_W-1:0] r_count;
            logic [ADDR_W-1:0] r_depth;
            logic [BUF_W-1:0]  r_buf;
            logic              r_done;
            logic              r_err;

            logic [ADDR_W-1:0] w_cfg;
            logic              w_hit;
            logic              w_in_order;

            assign w_cfg = cfg_depth[gi*ADDR_W +: ADDR_W];

            // load_start wins over a coincident write, so the write never
            // reaches the channel. Channels >= NUM_CH simply never match.
            assign w_hit      = wr_en && !load_start && (wr_ch == CH_W'(gi));
            assign w_in_order = (w_beat == r_beat) && (w_word == r_count);
            assign w_emit[gi] = w_hit && (r_state == ST_LOAD) && w_in_order && w_last;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state <= ST_IDLE;
                    r_beat  <= '0;
                    r_count <= '0;
                    r_depth <= '0;
                    r_buf   <= '0;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end else if (load_start) begin
                    r_depth <= w_cfg;
                    r_beat  <= '0;
                    r_count <= '0;
                    r_buf   <= '0;
                    r_err   <= 1'b0;
                    // An empty channel has nothing to load and is complete now.
                    if (w_cfg == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_LOAD;
                        r_done  <= 1'b0;
                    end
                end else if (w_hit) begin
                    case (r_state)
                        ST_LOAD: begin
                            if (w_in_order) begin
                                if (w_last) begin
                                    // Word is handed to the shared output
                                    // register this edge; start the next one.
                                    r_beat  <= '0;
                                    r_buf   <= '0;
                                    r_count <= r_count + 1'b1;
                                    if (r_count + 1'b1 == r_depth) begin
                                        r_state <= ST_DONE;
                                        r_done  <= 1'b1;
                                    end
                                end else begin
                                    r_buf[r_beat*TOP_WIDTH +: TOP_WIDTH] <= wr_din;
                                    r_beat <= r_beat + 1'b1;
                                end
                            end else begin
                                r_state <= ST_ERR;
                                r_err   <= 1'b1;
                                r_buf   <= '0;
                                r_beat  <= '0;
                            end
                        end
                        ST_DONE: begin
                            // Overflow: done stays set so the host can see
                            // how far the load got.
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            assign w_buf_all[gi] = r_buf;
            assign load_done[gi] = r_done;
            assign load_err[gi]  = r_err;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Word assembly: earlier beats from the emitting channel's buffer,
    // final beat straight from the bus.
    // ------------------------------------------------------------------
    logic [BUF_W-1:0] w_full;

    always_comb begin
        w_full = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_emit[i]) begin
                w_full = w_buf_all[i];
            end
        end
        w_full[(BEATS-1)*TOP_WIDTH +: TOP_WIDTH] = wr_din;
    end

    // ------------------------------------------------------------------
    // Shared registered outputs
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] r_bram_we;
    logic [ADDR_W-1:0] r_bram_addr;
    logic [DATA_W-1:0] r_bram_din;
    logic              r_all_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bram_we   <= '0;
            r_bram_addr <= '0;
            r_bram_din  <= '0;
            r_all_ready <= 1'b0;
        end else begin
            r_bram_we <= w_emit;
            if (|w_emit) begin
                r_bram_addr <= w_word;
                r_bram_din  <= w_full[DATA_W-1:0];
            end
            // Follows the flags by one cycle.
            r_all_ready <= (&load_done) && !(|load_err);
        end
    end

    assign bram_we   = r_bram_we;
    assign bram_addr = r_bram_addr;
    assign bram_din  = r_bram_din;
    assign all_ready = r_all_ready;

    // Byte-lane bits of the address and any lanes above DATA_W carry no
    // information for the BRAM.
    logic w_unused;
    assign w_unused = ^{wr_addr[1:0], w_full};

endmodule

// File: tb/tb_gat_bram_bridge.sv
module tb_gat_bram_bridge;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 18;
    localparam int TW     = 32;
    localparam int DW     = 64;
    localparam int BEATS  = 2;
    localparam int AW     = ADDR_W + 1 + 2;

    localparam int S_IDLE = 0;
    localparam int S_LOAD = 1;
    localparam int S_DONE = 2;
    localparam int S_ERR  = 3;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     load_start;
    logic [NUM_CH*ADDR_W-1:0] cfg_depth;
    logic                     wr_en;
    logic [1:0]               wr_ch;
    logic [AW-1:0]            wr_addr;
    logic [TW-1:0]            wr_din;
    logic [NUM_CH-1:0]        bram_we;
    logic [ADDR_W-1:0]        bram_addr;
    logic [DW-1:0]            bram_din;
    logic [NUM_CH-1:0]        load_done;
    logic [NUM_CH-1:0]        load_err;
    logic                     all_ready;

    gat_bram_bridge #(
        .TOP_WIDTH (TW),
        .NUM_CH    (NUM_CH),
        .DATA_W    (DW),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .cfg_depth  (cfg_depth),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_addr    (wr_addr),
        .wr_din     (wr_din),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .load_done  (load_done),
        .load_err   (load_err),
        .all_ready  (all_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [NUM_CH*ADDR_W-1:0] mkcfg(input int d0, input int d1, input int d2, input int d3);
        return {18'(d3), 18'(d2), 18'(d1), 18'(d0)};
    endfunction

    // Apply one cycle of inputs, let one rising edge pass, sample #1 later.
    task automatic drive(input logic ls, input logic [NUM_CH*ADDR_W-1:0] cfg, input logic we,
                         input logic [1:0] ch, input logic [AW-1:0] addr, input logic [TW-1:0] din);
        load_start = ls;
        cfg_depth  = cfg;
        wr_en      = we;
        wr_ch      = ch;
        wr_addr    = addr;
        wr_din     = din;
        @(posedge clk);
        #1;
        $display("txn t=%0t ls=%0b we=%0b ch=%0d addr=%h din=%h -> bram_we=%b addr=%h din=%h done=%b err=%b rdy=%b",
                 $time, ls, we, ch, addr, din, bram_we, bram_addr, bram_din, load_done, load_err, all_ready);
        load_start = 1'b0;
        wr_en      = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_we"},   64'(bram_we),   64'd0);
        check({tag, "_addr"}, 64'(bram_addr), 64'd0);
        check({tag, "_din"},  64'(bram_din),  64'd0);
        check({tag, "_done"}, 64'(load_done), 64'd0);
        check({tag, "_err"},  64'(load_err),  64'd0);
        check({tag, "_rdy"},  64'(all_ready), 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Reference model: each channel is a linear stream of 32-bit beats.
    // A write is accepted only if its byte address / 4 equals the number
    // of beats already received; every BEATS beats form one word.
    // ------------------------------------------------------------------
    int          m_state [NUM_CH];
    int          m_idx   [NUM_CH];
    int          m_depth [NUM_CH];
    logic [63:0] m_buf   [NUM_CH];
    logic [3:0]  m_done, m_err;
    logic [3:0]  x_we;
    logic [17:0] x_addr;
    logic [63:0] x_din;
    logic        x_rdy;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_state[c] = S_IDLE;
            m_idx[c]   = 0;
            m_depth[c] = 0;
            m_buf[c]   = '0;
        end
        m_done = '0;
        m_err  = '0;
    endtask

    task automatic model_edge(input logic ls, input logic [NUM_CH*ADDR_W-1:0] cfg, input logic we,
                              input logic [1:0] ch, input logic [AW-1:0] addr, input logic [TW-1:0] din);
        int c;
        int lane;
        x_rdy = (&m_done) && !(|m_err);
        x_we  = '0;
        if (ls) begin
            for (int k = 0; k < NUM_CH; k++) begin
                m_depth[k] = int'(cfg[k*ADDR_W +: ADDR_W]);
                m_idx[k]   = 0;
                m_buf[k]   = '0;
                m_err[k]   = 1'b0;
                m_state[k] = (m_depth[k] == 0) ? S_DONE : S_LOAD;
                m_done[k]  = (m_depth[k] == 0);
            end
        end else if (we) begin
            c = int'(ch);
            if (m_state[c] == S_LOAD) begin
                if (int'(addr >> 2) == m_idx[c]) begin
                    lane = m_idx[c] % BEATS;
                    m_buf[c][lane*TW +: TW] = din;
                    m_idx[c]++;
                    if (m_idx[c] % BEATS == 0) begin
                        x_we[c]  = 1'b1;
                        x_addr   = 18'(m_idx[c] / BEATS - 1);
                        x_din    = m_buf[c];
                        m_buf[c] = '0;
                        if (m_idx[c] / BEATS == m_depth[c]) begin
                            m_state[c] = S_DONE;
                            m_done[c]  = 1'b1;
                        end
                    end
                end else begin
                    m_state[c] = S_ERR;
                    m_err[c]   = 1'b1;
                end
            end else if (m_state[c] == S_DONE) begin
                m_state[c] = S_ERR;
                m_err[c]   = 1'b1;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        ls;
        logic        we;
        logic [1:0]  ch;
        logic [20:0] addr;
        logic [31:0] din;
        logic [3:0]  e_we;
        logic [17:0] e_addr;
        logic [63:0] e_din;
        logic [3:0]  e_done;
        logic [3:0]  e_err;
        logic        e_rdy;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [NUM_CH*ADDR_W-1:0] cfg;

        rst_n      = 1'b0;
        load_start = 1'b0;
        cfg_depth  = '0;
        wr_en      = 1'b0;
        wr_ch      = '0;
        wr_addr    = '0;
        wr_din     = '0;

        // depth: ch0=2, ch1=1, ch2=1, ch3=0
        tbl[0]  = '{1'b1, 1'b0, 2'd0, 21'd0,  32'h0,  4'b0000, 18'd0, 64'h0,                   4'b1000, 4'b0000, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 2'd0, 21'd0,  32'h11, 4'b0000, 18'd0, 64'h0,                   4'b1000, 4'b0000, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 2'd0, 21'd4,  32'h22, 4'b0001, 18'd0, 64'h00000022_00000011,   4'b1000, 4'b0000, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 2'd0, 21'd8,  32'h33, 4'b0000, 18'd0, 64'h0,                   4'b1000, 4'b0000, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 2'd0, 21'd12, 32'h44, 4'b0001, 18'd1, 64'h00000044_00000033,   4'b1001, 4'b0000, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 2'd1, 21'd4,  32'h55, 4'b0000, 18'd0, 64'h0,                   4'b1001, 4'b0010, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 2'd0, 21'd0,  32'h0,  4'b0000, 18'd0, 64'h0,                   4'b1001, 4'b0010, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 2'd2, 21'd0,  32'h66, 4'b0000, 18'd0, 64'h0,                   4'b1001, 4'b0010, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 2'd2, 21'd4,  32'h77, 4'b0100, 18'd0, 64'h00000077_00000066,   4'b1101, 4'b0010, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 2'd2, 21'd8,  32'h88, 4'b0000, 18'd0, 64'h0,                   4'b1101, 4'b0110, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 2'd1, 21'd0,  32'h99, 4'b0000, 18'd0, 64'h0,                   4'b1101, 4'b0110, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 2'd0, 21'd0,  32'h0,  4'b0000, 18'd0, 64'h0,                   4'b1101, 4'b0110, 1'b0};

        // Reset state
        #12;
        check_zero("reset");
        #1 rst_n = 1'b1;

        // Table: ordered packing, out-of-order error, overflow, ignored write
        cfg = mkcfg(2, 1, 1, 0);
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].ls, cfg, tbl[i].we, tbl[i].ch, tbl[i].addr, tbl[i].din);
            check($sformatf("tbl%0d_we", i), 64'(bram_we), 64'(tbl[i].e_we));
            if (tbl[i].e_we != 0) begin
                check($sformatf("tbl%0d_addr", i), 64'(bram_addr), 64'(tbl[i].e_addr));
                check($sformatf("tbl%0d_din", i),  bram_din,       tbl[i].e_din);
            end
            check($sformatf("tbl%0d_done", i), 64'(load_done), 64'(tbl[i].e_done));
            check($sformatf("tbl%0d_err", i),  64'(load_err),  64'(tbl[i].e_err));
            check($sformatf("tbl%0d_rdy", i),  64'(all_ready), 64'(tbl[i].e_rdy));
        end

        // load_start beats a coincident write
        cfg = mkcfg(1, 0, 0, 0);
        drive(1'b1, cfg, 1'b1, 2'd0, 21'd0, 32'hAA);
        check("ls_wr_we",   64'(bram_we),   64'd0);
        check("ls_wr_done", 64'(load_done), 64'b1110);
        check("ls_wr_err",  64'(load_err),  64'd0);
        drive(1'b0, cfg, 1'b1, 2'd0, 21'd0, 32'h1);
        check("ls_wr_b0_we", 64'(bram_we), 64'd0);
        drive(1'b0, cfg, 1'b1, 2'd0, 21'd4, 32'h2);
        check("ls_wr_b1_we",   64'(bram_we),   64'b0001);
        check("ls_wr_b1_addr", 64'(bram_addr), 64'd0);
        check("ls_wr_b1_din",  bram_din,       64'h00000002_00000001);
        check("ls_wr_b1_err",  64'(load_err),  64'd0);
        check("ls_wr_b1_rdy",  64'(all_ready), 64'd0);
        drive(1'b0, cfg, 1'b0, 2'd0, 21'd0, 32'h0);
        check("ls_wr_rdy", 64'(all_ready), 64'd1);

        // Asynchronous reset mid-word, then restart
        cfg = mkcfg(8, 0, 0, 0);
        drive(1'b1, cfg, 1'b0, 2'd0, 21'd0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, cfg, 1'b1, 2'd0, 21'(i * 4), 32'(100 + i));
        end
        drive(1'b0, cfg, 1'b1, 2'd0, 21'd40, 32'hDEAD);
        #2 rst_n = 1'b0;
        #1;
        check_zero("arst");
        @(posedge clk);
        #3 rst_n = 1'b1;
        drive(1'b0, cfg, 1'b1, 2'd0, 21'd44, 32'hBEEF);
        check("arst_idle_we",  64'(bram_we),  64'd0);
        check("arst_idle_err", 64'(load_err), 64'd0);
        drive(1'b1, cfg, 1'b0, 2'd0, 21'd0, 32'h0);
        drive(1'b0, cfg, 1'b1, 2'd0, 21'd0, 32'h5);
        drive(1'b0, cfg, 1'b1, 2'd0, 21'd4, 32'h6);
        check("arst_re_we",   64'(bram_we),   64'b0001);
        check("arst_re_addr", 64'(bram_addr), 64'd0);
        check("arst_re_din",  bram_din,       64'h00000006_00000005);

        // All channels loaded, ch3 empty: all_ready one cycle after last write
        cfg = mkcfg(1, 2, 1, 0);
        drive(1'b1, cfg, 1'b0, 2'd0, 21'd0, 32'h0);
        drive(1'b0, cfg, 1'b1, 2'd0, 21'd0,  32'hA0);
        drive(1'b0, cfg, 1'b1, 2'd0, 21'd4,  32'hA1);
        drive(1'b0, cfg, 1'b1, 2'd2, 21'd0,  32'hC0);
        drive(1'b0, cfg, 1'b1, 2'd2, 21'd4,  32'hC1);
        drive(1'b0, cfg, 1'b1, 2'd1, 21'd0,  32'hB0);
        drive(1'b0, cfg, 1'b1, 2'd1, 21'd4,  32'hB1);
        drive(1'b0, cfg, 1'b1, 2'd1, 21'd8,  32'hB2);
        drive(1'b0, cfg, 1'b1, 2'd1, 21'd12, 32'hB3);
        check("all_last_we",   64'(bram_we),   64'b0010);
        check("all_last_addr", 64'(bram_addr), 64'd1);
        check("all_last_din",  bram_din,       64'h000000B3_000000B2);
        check("all_last_done", 64'(load_done), 64'b1111);
        check("all_last_rdy",  64'(all_ready), 64'd0);
        drive(1'b0, cfg, 1'b0, 2'd0, 21'd0, 32'h0);
        check("all_rdy", 64'(all_ready), 64'd1);

        // Randomized traffic against the reference model
        rst_n = 1'b0;
        model_reset();
        #3 rst_n = 1'b1;
        cfg = mkcfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        model_edge(1'b1, cfg, 1'b0, 2'd0, 21'd0, 32'h0);
        drive(1'b1, cfg, 1'b0, 2'd0, 21'd0, 32'h0);
        check("rnd_init_done", 64'(load_done), 64'(m_done));
        for (int n = 0; n < 300; n++) begin
            int          r;
            logic        ls;
            logic        we;
            logic [1:0]  ch;
            logic [20:0] addr;
            logic [31:0] din;
            r    = $urandom_range(0, 99);
            ls   = 1'b0;
            we   = 1'b0;
            ch   = 2'($urandom_range(0, 3));
            addr = '0;
            din  = $urandom;
            if (r < 3) begin
                ls  = 1'b1;
                we  = ($urandom_range(0, 1) == 1);
                cfg = mkcfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            end else if (r >= 10) begin
                we = 1'b1;
                if (r < 90) addr = 21'(m_idx[ch] * 4 + $urandom_range(0, 3));
                else        addr = 21'($urandom_range(0, 31));
            end
            model_edge(ls, cfg, we, ch, addr, din);
            drive(ls, cfg, we, ch, addr, din);
            check($sformatf("rnd%0d_we", n), 64'(bram_we), 64'(x_we));
            if (x_we != 0) begin
                check($sformatf("rnd%0d_addr", n), 64'(bram_addr), 64'(x_addr));
                check($sformatf("rnd%0d_din", n),  bram_din,       x_din);
            end
            check($sformatf("rnd%0d_done", n), 64'(load_done), 64'(m_done));
            check($sformatf("rnd%0d_err", n),  64'(load_err),  64'(m_err));
            check($sformatf("rnd%0d_rdy", n),  64'(all_ready), 64'(x_rdy));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
